// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// master drives operands and out_ready; slave (the multiplier) drives results and in_ready.
interface fp_mul_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  logic         ovf;
  logic         unf;
  logic         inv;
  logic         ex;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, p, ovf, unf, inv, ex
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, p, ovf, unf, inv, ex
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack, normalise/round, pack) with a
// single global advance enable so a stalled output freezes the whole pipe.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mul_pipe_if.slave  bus
);
  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned PROD_W  = 2 * MAN_W + 2;
  localparam int unsigned XW      = EXP_W + 2;
  localparam int unsigned BIAS    = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned EXP_MAX = 2 ** EXP_W - 1;

  typedef struct packed {
    logic              sign;
    logic              inv;
    logic              inf;
    logic              zero;
    logic              rnd;
    logic [XW-1:0]     exp;
    logic [PROD_W-1:0] prod;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             inv;
    logic             inf;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [MAN_W-1:0] frac;
  } s2_t;

  logic         adv_c;
  logic         v1_q, v2_q, v3_q;
  s1_t          s1_d, s1_q;
  s2_t          s2_d, s2_q;
  logic [W-1:0] p_d, p_q;
  logic         ovf_d, unf_d, inv_d;
  logic         ovf_q, unf_q, inv_q, ex_q;

  assign adv_c         = bus.out_ready | ~v3_q;
  assign bus.in_ready  = adv_c;
  assign bus.out_valid = v3_q;
  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.inv       = inv_q;
  assign bus.ex        = ex_q;

  // Stage 1: classify operands, biased exponent sum, full significand product.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  always_comb begin
    ea     = bus.a[W-2 -: EXP_W];
    eb     = bus.b[W-2 -: EXP_W];
    fa     = bus.a[MAN_W-1:0];
    fb     = bus.b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);

    s1_d      = '0;
    s1_d.sign = bus.a[W-1] ^ bus.b[W-1];
    s1_d.inv  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    s1_d.inf  = a_inf | b_inf;
    s1_d.zero = a_zero | b_zero;
    s1_d.rnd  = bus.rnd_mode;
    s1_d.exp  = XW'(ea) + XW'(eb) - XW'(BIAS);
    s1_d.prod = PROD_W'({1'b1, fa}) * PROD_W'({1'b1, fb});
  end

  // Stage 2: left-justify the product, then round on guard/sticky.
  logic [PROD_W-1:0] norm;
  logic [SIG_W-1:0]  sig;
  logic              guard, sticky, inc;
  logic [SIG_W:0]    sig_r;

  always_comb begin
    norm   = s1_q.prod[PROD_W-1] ? s1_q.prod : (s1_q.prod << 1);
    sig    = norm[PROD_W-1 -: SIG_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    inc    = ~s1_q.rnd & guard & (sticky | sig[0]);
    sig_r  = {1'b0, sig} + (SIG_W + 1)'(inc);

    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.inv  = s1_q.inv;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.exp  = s1_q.exp + XW'(s1_q.prod[PROD_W-1]) + XW'(sig_r[SIG_W]);
    // A rounding carry-out leaves 1.000..0, so the stored fraction is zero.
    s2_d.frac = sig_r[SIG_W] ? '0 : sig_r[MAN_W-1:0];
  end

  // Stage 3: special cases in priority order, then range check and pack.
  logic exp_hi, exp_lo;

  always_comb begin
    p_d    = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inv_d  = 1'b0;
    exp_hi = ~s2_q.exp[XW-1] && (s2_q.exp >= XW'(EXP_MAX));
    exp_lo = s2_q.exp[XW-1] || (s2_q.exp == '0);

    if (s2_q.inv) begin
      p_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, (MAN_W - 1)'(0)};
      inv_d = 1'b1;
    end else if (s2_q.inf) begin
      p_d = {s2_q.sign, {EXP_W{1'b1}}, MAN_W'(0)};
    end else if (s2_q.zero) begin
      p_d = {s2_q.sign, (W - 1)'(0)};
    end else if (exp_hi) begin
      p_d   = {s2_q.sign, {EXP_W{1'b1}}, MAN_W'(0)};
      ovf_d = 1'b1;
    end else if (exp_lo) begin
      p_d   = {s2_q.sign, (W - 1)'(0)};
      unf_d = 1'b1;
    end else begin
      p_d = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.frac};
    end
  end

  // Pipeline registers: everything moves together on adv, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      p_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
      ex_q  <= 1'b0;
    end else if (adv_c) begin
      v1_q  <= bus.in_valid;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      p_q   <= p_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
      ex_q  <= ovf_d | unf_d | inv_d;
    end
  end
endmodule
